// File: rtl/wb_gpio_in.sv
// Wishbone classic slave for external input pins: synchroniser, per-bit edge detection,
// write-1-to-clear event status and a level interrupt for the CPU irq vector.
module wb_gpio_in #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic             irq_o
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RISE_EN = 2'd1;
  localparam logic [1:0] ADDR_FALL_EN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;

  logic             req;
  logic             wr;
  logic [1:0]       reg_sel;
  logic [31:0]      lane_mask;
  logic [31:0]      masked_dat;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [31:0]      rd_data;
  logic             unused_adr;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign reg_sel = wb_adr_i[3:2];

  // A request is accepted on the edge that raises ack; ack itself blocks re-acceptance.
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr  = req & wb_we_i;

  assign lane_mask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign masked_dat = wb_dat_i & lane_mask;
  assign wmask      = lane_mask[WIDTH-1:0];
  assign wdata      = masked_dat[WIDTH-1:0];

  assign clr  = (wr && reg_sel == ADDR_STATUS) ? wdata : '0;
  assign rise = sync & ~prev_q & rise_en_q;
  assign fall = ~sync & prev_q & fall_en_q;

  assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

  always_comb begin
    rd_data = '0;
    unique case (reg_sel)
      ADDR_DATA:    rd_data[WIDTH-1:0] = sync;
      ADDR_RISE_EN: rd_data[WIDTH-1:0] = rise_en_q;
      ADDR_FALL_EN: rd_data[WIDTH-1:0] = fall_en_q;
      ADDR_STATUS:  rd_data[WIDTH-1:0] = status_q;
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_o     <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync;

      // New events are OR-ed in after the clear so a same-cycle set wins.
      status_q <= (status_q & ~clr) | rise | fall;
      irq_o    <= |status_q;

      wb_ack_o <= req;
      if (req) wb_dat_o <= rd_data;

      if (wr && reg_sel == ADDR_RISE_EN) rise_en_q <= (rise_en_q & ~wmask) | wdata;
      if (wr && reg_sel == ADDR_FALL_EN) fall_en_q <= (fall_en_q & ~wmask) | wdata;
    end
  end

endmodule

// File: doc/wb_gpio_in.md
Name: wb_gpio_in

Overview:
- Wishbone classic slave that reads external input pins. It is the input-direction counterpart of the LED/GPIO output slave.
- Synchronises up to 32 asynchronous inputs and detects per-bit rising and falling edges.
- Latches edge events into a write-1-to-clear status register and drives a level interrupt into one bit of the picorv32 irq vector.
- Sits on the wb_intercon slave side beside the RAM and LED slaves.

Parameters:
- WIDTH, 32, number of input pins (1..32); data bits [31:WIDTH] read as 0, writes ignored.
- SYNC_STAGES, 2, flops in the input synchroniser chain (min 2).

Ports:
- clk_i  in  1  system clock; all logic on its rising edge
- rst_i  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  byte address; only [3:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- gpio_i  in  WIDTH  asynchronous input pins
- irq_o  out  1  interrupt, active-high level

Behaviour:
- Reset, while rst_i is high at a clock edge:
  - wb_ack_o=0, wb_dat_o=0, irq_o=0.
  - Synchroniser flops, prev register, RISE_EN, FALL_EN and STATUS all clear to 0.
- Register map, by wb_adr_i[3:2]:
  - 0 DATA (RO): synchronised inputs; writes ignored.
  - 1 RISE_EN (RW): per-bit rising-edge enable.
  - 2 FALL_EN (RW): per-bit falling-edge enable.
  - 3 STATUS (R/W1C): pending edge events.
- Handshake:
  - wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - Ack is always one cycle after a new request and lasts exactly one cycle.
  - Back-to-back requests therefore see ack every other cycle.
  - No err/rty outputs; the system ties them to 0.
- Reads:
  - wb_dat_o is registered on the same edge that raises ack, from register values before that edge.
  - wb_dat_o holds its value while ack is low.
- Writes:
  - Take effect on the ack edge only.
  - Byte lane k is written only when wb_sel_i[k]=1.
  - For STATUS, a 1 in an enabled lane clears that bit; 0 leaves it unchanged.
- Synchroniser: gpio_i passes through SYNC_STAGES flops; the last stage is sync.
- Edge detect:
  - prev <= sync every cycle.
  - rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
  - STATUS <= (STATUS & ~clr) | rise | fall.
  - When a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq_o: registered, irq_o <= |STATUS.
- Latency (SYNC_STAGES=2), for gpio_i stable before edge N:
  - DATA reflects it after edge N+1.
  - STATUS bit set after edge N+2.
  - irq_o high after edge N+3.
  - In general, DATA at N+SYNC_STAGES-1, STATUS at N+SYNC_STAGES, irq_o at N+SYNC_STAGES+1.
- Enable handling:
  - Changing RISE_EN/FALL_EN never clears STATUS.
  - Enabling a bit does not create an event for a level already present; only transitions after the enable edge count.
- Pulses shorter than one clock may be missed; no filtering is performed.
- Reset mid-transaction: ack is forced low, any in-flight write is discarded, and the master must reissue.
- A cyc/stb drop before ack aborts the request with no side effects.
- After reset release with gpio_i=1, no event is latched because the enables are 0.

Test Plan:
- Reset with gpio_i=32'hFFFF_FFFF -> all outputs 0; after reset, DATA read = 32'hFFFF_FFFF, STATUS = 0, irq_o = 0.
- Write RISE_EN=32'h0000_0001; drive gpio_i[0] 0->1 before edge N -> STATUS=32'h1 after edge N+2, irq_o=1 after edge N+3; W1C 32'h1 -> STATUS=0, irq_o=0 one cycle after ack.
- FALL_EN=32'h8000_0000 with RISE_EN=0; toggle bit 31 1->0->1 -> only one event latched, STATUS=32'h8000_0000.
- Byte-lane write to RISE_EN: data 32'hAABB_CCDD with sel=4'b0100 -> RISE_EN reads 32'h00BB_0000.
- Edge on bit 3 in the same cycle as a W1C of 32'h8 -> STATUS bit 3 remains 1 and irq_o stays high.
- Assert rst_i for one cycle while stb is pending with a RISE_EN write of 32'hFF -> no ack in that cycle, RISE_EN=0; reissued write acks one cycle after the request.
